// File: rtl/mem_stage_pkg.sv
// Shared pipeline types for the memory-access stage.
// Load/store funct3 encodings and the MEM-stage FSM states.
package mem_stage_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam int MEM_W = 32;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for the MEM stage: byte enables,
// store-data alignment, access legality and load extension.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic        i_access,
    input  logic        i_store,
    input  logic [31:0] i_rs2,
    output logic [3:0]  o_mbe,
    output logic [31:0] o_wdata,
    output logic        o_err,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_offset,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ext
);

    logic       w_bad_f3;
    logic       w_misalign;
    logic       w_st_unsigned;
    logic [4:0] w_shamt;
    logic [7:0] w_byte;
    logic [15:0] w_half;

    assign w_shamt = {i_offset, 3'b000};

    // Request side: lane masks and shifted store data
    always_comb begin
        o_mbe   = 4'b1111;
        o_wdata = i_rs2;
        case (i_funct3[1:0])
            2'b00: begin
                o_mbe   = 4'b0001 << i_offset;
                o_wdata = {24'b0, i_rs2[7:0]} << w_shamt;
            end
            2'b01: begin
                o_mbe   = 4'b0011 << i_offset;
                o_wdata = {16'b0, i_rs2[15:0]} << w_shamt;
            end
            default: begin
                o_mbe   = 4'b1111;
                o_wdata = i_rs2;
            end
        endcase
        if (!i_store) begin
            o_mbe = 4'b1111;
        end
    end

    // Legality: reserved encodings, misalignment, unsigned stores
    always_comb begin
        w_bad_f3      = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) ||
                        (i_funct3 == 3'b111);
        w_misalign    = 1'b0;
        if (i_funct3[1:0] == 2'b01) begin
            w_misalign = i_offset[0];
        end else if (i_funct3[1:0] == 2'b10) begin
            w_misalign = (i_offset != 2'b00);
        end
        w_st_unsigned = i_store && i_funct3[2];
        o_err         = i_access && (w_bad_f3 || w_misalign || w_st_unsigned);
    end

    // Response side: pick the addressed lane and extend it
    always_comb begin
        w_byte = i_rdata[{i_ld_offset, 3'b000} +: 8];
        w_half = i_ld_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_ext  = i_rdata;
        case (i_ld_funct3)
            LB:      o_ext = {{24{w_byte[7]}}, w_byte};
            LBU:     o_ext = {24'b0, w_byte};
            LH:      o_ext = {{16{w_half[15]}}, w_half};
            LHU:     o_ext = {16'b0, w_half};
            default: o_ext = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: registers one data-memory request per
// instruction, waits for the response and stalls the pipe meanwhile.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             mem_read_i,
    input  logic             mem_write_i,
    input  logic [2:0]       funct3_i,
    input  logic [width-1:0] alu_out_i,
    input  logic [width-1:0] rs2_out_i,
    input  logic             load_i,
    input  logic             dmem_resp,
    input  logic [width-1:0] dmem_rdata,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [width-1:0] dmem_address,
    output logic [width-1:0] dmem_wdata,
    output logic [3:0]       dmem_mbe,
    output logic [width-1:0] mem_rdata_o,
    output logic             stall_o,
    output logic             mem_err_o
);

    mem_state_t       r_state;
    logic             r_read;
    logic             r_write;
    logic [width-1:0] r_addr;
    logic [width-1:0] r_wdata;
    logic [3:0]       r_mbe;
    logic [2:0]       r_funct3;
    logic [1:0]       r_offset;
    logic             r_is_load;
    logic [width-1:0] r_rdata;

    logic             w_access;
    logic             w_memop;
    logic             w_err;
    logic [3:0]       w_mbe;
    logic [width-1:0] w_wdata;
    logic [width-1:0] w_ext;

    assign w_access = valid_i && (mem_read_i || mem_write_i);
    assign w_memop  = w_access && !w_err;

    mem_align u_align (
        .i_funct3    (funct3_i),
        .i_offset    (alu_out_i[1:0]),
        .i_access    (w_access),
        .i_store     (mem_write_i),
        .i_rs2       (rs2_out_i),
        .o_mbe       (w_mbe),
        .o_wdata     (w_wdata),
        .o_err       (w_err),
        .i_ld_funct3 (r_funct3),
        .i_ld_offset (r_offset),
        .i_rdata     (dmem_rdata),
        .o_ext       (w_ext)
    );

    // Request FSM: latch in IDLE, hold in BUSY, park in DONE until advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_mbe     <= 4'b0;
            r_funct3  <= 3'b0;
            r_offset  <= 2'b0;
            r_is_load <= 1'b0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_memop) begin
                        r_read    <= !mem_write_i;
                        r_write   <= mem_write_i;
                        r_addr    <= {alu_out_i[width-1:2], 2'b00};
                        r_wdata   <= w_wdata;
                        r_mbe     <= w_mbe;
                        r_funct3  <= funct3_i;
                        r_offset  <= alu_out_i[1:0];
                        r_is_load <= !mem_write_i;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (dmem_resp) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        if (r_is_load) begin
                            r_rdata <= w_ext;
                        end
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (load_i) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign stall_o      = w_memop && (r_state != DONE);
    assign mem_err_o    = w_err;
    assign dmem_read    = r_read;
    assign dmem_write   = r_write;
    assign dmem_address = r_addr;
    assign dmem_wdata   = r_wdata;
    assign dmem_mbe     = r_mbe;
    assign mem_rdata_o  = r_rdata;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with a byte-lane reference model.
// Directed plan cases followed by randomized loads/stores.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] alu_out_i;
    logic [31:0] rs2_out_i;
    logic        load_i;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mbe;
    logic [31:0] mem_rdata_o;
    logic        stall_o;
    logic        mem_err_o;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_rdata = 32'h0;

    mem_stage #(.width(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .alu_out_i    (alu_out_i),
        .rs2_out_i    (rs2_out_i),
        .load_i       (load_i),
        .dmem_resp    (dmem_resp),
        .dmem_rdata   (dmem_rdata),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_address (dmem_address),
        .dmem_wdata   (dmem_wdata),
        .dmem_mbe     (dmem_mbe),
        .mem_rdata_o  (mem_rdata_o),
        .stall_o      (stall_o),
        .mem_err_o    (mem_err_o)
    );

    always #5 clk = ~clk;

    function automatic int m_size(input logic [2:0] f3);
        int s;
        s = 1;
        if (f3 == 3'd1 || f3 == 3'd5) s = 2;
        if (f3 == 3'd2) s = 4;
        return s;
    endfunction

    function automatic bit m_err(input bit rd, input bit wr,
                                 input logic [2:0] f3, input logic [31:0] a);
        if (!(rd || wr)) return 1'b0;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (wr && f3 >= 3'd4) return 1'b1;
        return (a % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_mbe(input bit wr, input logic [2:0] f3,
                                         input logic [31:0] a);
        int v;
        if (!wr) return 4'hF;
        v = ((1 << m_size(f3)) - 1) << (a % 4);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] d);
        longint unsigned v;
        longint unsigned mask;
        mask = (64'd1 << (8 * m_size(f3))) - 1;
        v = (longint'(d) & mask) << (8 * (a % 4));
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v;
        int sz;
        sz = m_size(f3);
        v = rd >> (8 * (a % 4));
        if (sz == 1) begin
            v = v & 32'hFF;
            if (f3 < 3'd4 && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (f3 < 3'd4 && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic run_op(input string nm, input bit rd, input bit wr,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rdat,
                          input int delay);
        bit e_err;
        bit strobe;
        bit prev;
        bit done;
        int stalls;
        int reqs;
        int busy;
        int n;
        @(negedge clk);
        valid_i = 1'b1;
        mem_read_i = rd;
        mem_write_i = wr;
        funct3_i = f3;
        alu_out_i = a;
        rs2_out_i = d;
        load_i = 1'b0;
        dmem_resp = 1'b0;
        dmem_rdata = rdat;
        #1;
        e_err = m_err(rd, wr, f3, a);
        total++;
        if (mem_err_o !== e_err) begin
            bad++;
            $display("FAIL %s err got=%b exp=%b", nm, mem_err_o, e_err);
        end
        if (e_err) begin
            total++;
            if (stall_o !== 1'b0) begin
                bad++;
                $display("FAIL %s err_stall got=%b exp=0", nm, stall_o);
            end
            @(negedge clk);
            #1;
            total++;
            if ((dmem_read | dmem_write) !== 1'b0) begin
                bad++;
                $display("FAIL %s err_strobe got=%b%b exp=00", nm,
                         dmem_read, dmem_write);
            end
            load_i = 1'b1;
            return;
        end
        stalls = 0;
        reqs = 0;
        busy = 0;
        prev = 1'b0;
        done = 1'b0;
        n = 0;
        while (n < 60) begin
            if (stall_o === 1'b1) stalls++;
            strobe = dmem_read | dmem_write;
            if (strobe && !prev) begin
                reqs++;
                total++;
                if (dmem_address !== (a & 32'hFFFF_FFFC) ||
                    dmem_mbe !== m_mbe(wr, f3, a) ||
                    dmem_write !== wr || dmem_read !== (rd && !wr) ||
                    (wr && dmem_wdata !== m_wdata(f3, a, d))) begin
                    bad++;
                    $display("FAIL %s req got a=%h m=%b w=%h rw=%b%b exp a=%h m=%b w=%h",
                             nm, dmem_address, dmem_mbe, dmem_wdata,
                             dmem_read, dmem_write, a & 32'hFFFF_FFFC,
                             m_mbe(wr, f3, a), m_wdata(f3, a, d));
                end
            end
            prev = strobe;
            if (stall_o !== 1'b1 && n > 0) begin
                done = 1'b1;
                break;
            end
            if (strobe) busy++;
            dmem_resp = strobe && (busy == delay);
            @(negedge clk);
            #1;
            n++;
        end
        dmem_resp = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s timeout waiting for DONE", nm);
        end
        total++;
        if (stalls != delay + 1 || reqs != 1) begin
            bad++;
            $display("FAIL %s stall/req got=%0d/%0d exp=%0d/1", nm,
                     stalls, reqs, delay + 1);
        end
        if (rd && !wr) exp_rdata = m_load(f3, a, rdat);
        dmem_resp = 1'b1;
        dmem_rdata = ~rdat;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (mem_rdata_o !== exp_rdata || stall_o !== 1'b0 ||
                (dmem_read | dmem_write) !== 1'b0) begin
                bad++;
                $display("FAIL %s done got=%h st=%b sb=%b exp=%h st=0 sb=0",
                         nm, mem_rdata_o, stall_o, dmem_read | dmem_write,
                         exp_rdata);
            end
            @(negedge clk);
            #1;
            dmem_resp = 1'b0;
        end
        load_i = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_i = 1'b0;
        mem_read_i = 1'b0;
        mem_write_i = 1'b0;
        funct3_i = 3'b0;
        alu_out_i = 32'h0;
        rs2_out_i = 32'h0;
        load_i = 1'b0;
        dmem_resp = 1'b0;
        dmem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
             mem_rdata_o, stall_o, mem_err_o} !== '0) begin
            bad++;
            $display("FAIL reset outputs rd=%b wr=%b a=%h w=%h m=%b r=%h st=%b e=%b exp all 0",
                     dmem_read, dmem_write, dmem_address, dmem_wdata,
                     dmem_mbe, mem_rdata_o, stall_o, mem_err_o);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = 32'h0;
    endtask

    task automatic test_plan();
        run_op("lw", 1, 0, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 1);
        run_op("lb", 1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 1);
        total++;
        if (mem_rdata_o !== 32'hFFFF_FF80) begin
            bad++;
            $display("FAIL lb_const got=%h exp=ffffff80", mem_rdata_o);
        end
        run_op("lbu", 1, 0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_0000, 2);
        total++;
        if (mem_rdata_o !== 32'h0000_0080) begin
            bad++;
            $display("FAIL lbu_const got=%h exp=00000080", mem_rdata_o);
        end
        run_op("sh", 0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 4);
        run_op("lw_mis", 1, 0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 1);
        run_op("f3_011", 1, 0, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 1);
        run_op("sbu", 0, 1, 3'b100, 32'h0000_3000, 32'h0, 32'h0, 1);
    endtask

    task automatic test_bubble();
        @(negedge clk);
        load_i = 1'b1;
        valid_i = 1'b0;
        mem_read_i = 1'b1;
        mem_write_i = 1'b0;
        funct3_i = 3'b011;
        alu_out_i = 32'h0000_0003;
        #1;
        total++;
        if (stall_o !== 1'b0 || mem_err_o !== 1'b0) begin
            bad++;
            $display("FAIL bubble got st=%b e=%b exp 0 0", stall_o, mem_err_o);
        end
        @(negedge clk);
        #1;
        total++;
        if ((dmem_read | dmem_write) !== 1'b0) begin
            bad++;
            $display("FAIL bubble_strobe got=%b exp=0", dmem_read | dmem_write);
        end
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        load_i = 1'b0;
        valid_i = 1'b1;
        mem_read_i = 1'b1;
        mem_write_i = 1'b0;
        funct3_i = 3'b010;
        alu_out_i = 32'h0000_4000;
        dmem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        #1;
        total++;
        if (dmem_read !== 1'b1) begin
            bad++;
            $display("FAIL rbusy_issue got=%b exp=1", dmem_read);
        end
        rst = 1'b1;
        #1;
        exp_rdata = 32'h0;
        total++;
        if ((dmem_read | dmem_write) !== 1'b0 || mem_rdata_o !== 32'h0) begin
            bad++;
            $display("FAIL rbusy_drop got sb=%b r=%h exp sb=0 r=0",
                     dmem_read | dmem_write, mem_rdata_o);
        end
        @(negedge clk);
        rst = 1'b0;
        valid_i = 1'b0;
        dmem_resp = 1'b1;
        @(negedge clk);
        #1;
        dmem_resp = 1'b0;
        total++;
        if ((dmem_read | dmem_write) !== 1'b0 || mem_rdata_o !== 32'h0 ||
            stall_o !== 1'b0) begin
            bad++;
            $display("FAIL rbusy_resp got sb=%b r=%h st=%b exp 0",
                     dmem_read | dmem_write, mem_rdata_o, stall_o);
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_lw", 1, 0, 3'b010, 32'h0000_5008, 32'h0, 32'h0BAD_F00D, 2);
        @(negedge clk);
        load_i = 1'b1;
        valid_i = 1'b1;
        mem_read_i = 1'b0;
        mem_write_i = 1'b0;
        funct3_i = 3'b000;
        alu_out_i = 32'h0000_0007;
        #1;
        total++;
        if (stall_o !== 1'b0 || mem_err_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_add got st=%b e=%b exp 0 0", stall_o, mem_err_o);
        end
        @(negedge clk);
        #1;
        total++;
        if ((dmem_read | dmem_write) !== 1'b0) begin
            bad++;
            $display("FAIL b2b_add_strobe got=%b exp=0", dmem_read | dmem_write);
        end
        run_op("b2b_sw", 0, 1, 3'b010, 32'h0000_500C, 32'hCAFE_1234, 32'h0, 3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int kind;
            bit rd;
            bit wr;
            logic [2:0] f3;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            rd = (kind != 1);
            wr = (kind != 0);
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 :
                         (f3[1:0] == 2'b01) ? {a[1], 1'b0} : a[1:0];
            end
            run_op("rand", rd, wr, f3, a, $urandom, $urandom,
                   $urandom_range(1, 4));
        end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_bubble();
        test_reset_busy();
        test_back_to_back();
        test_random();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
